// File: rtl/belt_writeback.sv
// belt_writeback: collects results from two functional-unit ports, buffers
// them in a small in-order circular FIFO and drains one entry per enabled
// cycle into the belt push port. src0 is ordered ahead of src1 in a cycle.
module belt_writeback #(
  parameter int BIT_WIDTH  = 47,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               async_rst,
  input  logic                               clk_en,
  input  logic                               flush,
  input  logic                               src0_valid,
  input  logic [BIT_WIDTH-1:0]               src0_data,
  output logic                               src0_ready,
  input  logic                               src1_valid,
  input  logic [BIT_WIDTH-1:0]               src1_data,
  output logic                               src1_ready,
  output logic                               belt_push,
  output logic [BIT_WIDTH-1:0]               belt_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    occupancy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [BIT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     free;
  logic [PTR_W-1:0]     wr1_addr;
  logic [1:0]           n_wr;
  logic                 active;
  logic                 wr0, wr1, pop;

  // Handshakes only complete on an enabled, non-flushing cycle outside reset.
  assign active = clk_en & ~flush & ~async_rst;

  // Free space comes from the registered count only; a same-cycle pop does
  // not open a slot, which keeps the count bounded without a pop->ready path.
  assign free       = CNT_W'(FIFO_DEPTH) - count_q;
  assign src0_ready = active & (free != '0);
  assign src1_ready = active & ((free >= CNT_W'(2)) | ((free != '0) & ~src0_valid));

  assign wr0  = src0_valid & src0_ready;
  assign wr1  = src1_valid & src1_ready;
  assign n_wr = {1'b0, wr0} + {1'b0, wr1};
  assign pop  = active & (count_q != '0);

  // src1 lands behind src0 when both transfer in the same cycle.
  assign wr1_addr = wr0 ? (wptr_q + PTR_W'(1)) : wptr_q;

  assign belt_push = pop;
  assign belt_data = mem_q[rptr_q];
  assign occupancy = count_q;

  // Next-state for pointers and count: flush clears, otherwise advance.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clk_en && flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      wptr_d  = wptr_q + PTR_W'(n_wr);
      rptr_d  = rptr_q + PTR_W'(pop);
      count_d = count_q + CNT_W'(n_wr) - CNT_W'(pop);
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk) begin
    if (wr0) mem_q[wptr_q]   <= src0_data;
    if (wr1) mem_q[wr1_addr] <= src1_data;
  end

endmodule

// File: tb/tb_belt_writeback.sv
// Testbench for belt_writeback: directed scenarios plus a randomized
// back-pressure run, with an in-order scoreboard of belt pushes.
module tb_belt_writeback;

  localparam int W     = 47;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          async_rst;
  logic          clk_en;
  logic          flush;
  logic          src0_valid;
  logic [W-1:0]  src0_data;
  logic          src0_ready;
  logic          src1_valid;
  logic [W-1:0]  src1_data;
  logic          src1_ready;
  logic          belt_push;
  logic [W-1:0]  belt_data;
  logic [CW-1:0] occupancy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q [$];
  logic [W-1:0] got_mem [0:1023];
  int           got_wr = 0;
  int           got_rd = 0;

  belt_writeback #(.BIT_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .async_rst  (async_rst),
    .clk_en     (clk_en),
    .flush      (flush),
    .src0_valid (src0_valid),
    .src0_data  (src0_data),
    .src0_ready (src0_ready),
    .src1_valid (src1_valid),
    .src1_data  (src1_data),
    .src1_ready (src1_ready),
    .belt_push  (belt_push),
    .belt_data  (belt_data),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  // Record every belt push, sampled mid-cycle.
  always @(negedge clk) begin
    if (belt_push === 1'b1) begin
      got_mem[got_wr] <= belt_data;
      got_wr          <= got_wr + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    src0_data  = '0;
    src1_data  = '0;
    flush      = 1'b0;
    clk_en     = 1'b1;
  endtask

  task automatic test_reset();
    logic [W-1:0] a, b;
    a = 47'h0AAA_0000_0001;
    b = 47'h0BBB_0000_0002;
    idle_inputs();
    async_rst = 1'b1;
    #3;
    checks++;
    if (occupancy !== '0 || src0_ready !== 1'b0 || src1_ready !== 1'b0 || belt_push !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: occ=%0d r0=%b r1=%b push=%b, required 0 0 0 0",
               occupancy, src0_ready, src1_ready, belt_push);
    end
    step();
    async_rst = 1'b0;
    @(negedge clk);
    checks++;
    if (src0_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: src0_ready=%b required 1", src0_ready);
    end
    // Build occupancy 3: dual write into empty, then dual write at occupancy 2.
    step();
    src0_valid = 1'b1; src0_data = a;
    src1_valid = 1'b1; src1_data = b;
    step();
    src0_data = 47'h0CCC_0000_0003;
    src1_data = 47'h0DDD_0000_0004;
    step();
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (occupancy !== CW'(3)) begin
      errors++;
      $display("FAIL reset_fill_occ: occupancy=%0d required 3", occupancy);
    end
    #2;
    async_rst = 1'b1;
    #1;
    checks++;
    if (occupancy !== '0 || belt_push !== 1'b0 || src0_ready !== 1'b0 || src1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_midop: occ=%0d push=%b r0=%b r1=%b, required 0 0 0 0",
               occupancy, belt_push, src0_ready, src1_ready);
    end
    // Only the two entries popped before the reset may have reached the belt.
    checks++;
    if (got_wr - got_rd !== 2 || got_mem[got_rd] !== a || got_mem[got_rd+1] !== b) begin
      errors++;
      $display("FAIL reset_prepush: count=%0d first=%h second=%h, required 2 %h %h",
               got_wr - got_rd, got_mem[got_rd], got_mem[got_rd+1], a, b);
    end
    got_rd = got_wr;
    step();
    async_rst = 1'b0;
    @(negedge clk);
    checks++;
    if (src0_ready !== 1'b1 || belt_push !== 1'b0 || occupancy !== '0) begin
      errors++;
      $display("FAIL reset_after: r0=%b push=%b occ=%0d, required 1 0 0",
               src0_ready, belt_push, occupancy);
    end
    step();
    step();
    checks++;
    if (got_wr !== got_rd) begin
      errors++;
      $display("FAIL reset_no_push: pushes=%0d required 0", got_wr - got_rd);
    end
    got_rd = got_wr;
    exp_q.delete();
  endtask

  task automatic test_dual_write();
    logic [W-1:0] g, e;
    src0_valid = 1'b1; src0_data = 47'h11;
    src1_valid = 1'b1; src1_data = 47'h22;
    exp_q.push_back(47'h11);
    exp_q.push_back(47'h22);
    @(negedge clk);
    checks++;
    if (src0_ready !== 1'b1 || src1_ready !== 1'b1) begin
      errors++;
      $display("FAIL dual_ready: r0=%b r1=%b required 1 1", src0_ready, src1_ready);
    end
    step();
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (occupancy !== CW'(2) || belt_push !== 1'b1 || belt_data !== 47'h11) begin
      errors++;
      $display("FAIL dual_n1: occ=%0d push=%b data=%h, required 2 1 11", occupancy, belt_push, belt_data);
    end
    step();
    @(negedge clk);
    checks++;
    if (occupancy !== CW'(1) || belt_push !== 1'b1 || belt_data !== 47'h22) begin
      errors++;
      $display("FAIL dual_n2: occ=%0d push=%b data=%h, required 1 1 22", occupancy, belt_push, belt_data);
    end
    step();
    @(negedge clk);
    checks++;
    if (occupancy !== '0 || belt_push !== 1'b0) begin
      errors++;
      $display("FAIL dual_n3: occ=%0d push=%b, required 0 0", occupancy, belt_push);
    end
    step();
    while (got_rd < got_wr) begin
      g = got_mem[got_rd];
      got_rd++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dual_sb_extra: got %h, required no push", g);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL dual_sb: got %h required %h", g, e);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL dual_sb_missing: %0d values never pushed, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] g, e;
    for (int i = 0; i < 10; i++) begin
      src0_valid = 1'b1;
      src0_data  = W'(i);
      @(negedge clk);
      checks++;
      if (src0_ready !== 1'b1) begin
        errors++;
        $display("FAIL wrap_ready[%0d]: src0_ready=%b required 1", i, src0_ready);
      end else begin
        exp_q.push_back(W'(i));
      end
      step();
    end
    src0_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    @(negedge clk);
    checks++;
    if (occupancy !== '0) begin
      errors++;
      $display("FAIL wrap_empty: occupancy=%0d required 0", occupancy);
    end
    step();
    while (got_rd < got_wr) begin
      g = got_mem[got_rd];
      got_rd++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wrap_sb_extra: got %h, required no push", g);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL wrap_sb: got %h required %h", g, e);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_sb_missing: %0d values never pushed, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] g, e;
    logic [63:0]  r;
    logic         v0, v1, er0, er1, a0, a1, p0, p1;
    logic [W-1:0] d0, d1;
    int           mocc, free, saw_split;
    mocc = 0; p0 = 1'b0; p1 = 1'b0; saw_split = 0;
    d0 = '0; d1 = '0;
    for (int c = 0; c < 200; c++) begin
      if (!p0) begin
        v0 = ($urandom_range(0, 3) != 0);
        r  = {$urandom(), $urandom()};
        d0 = r[W-1:0];
      end else v0 = 1'b1;
      if (!p1) begin
        v1 = ($urandom_range(0, 4) != 0);
        r  = {$urandom(), $urandom()};
        d1 = r[W-1:0];
      end else v1 = 1'b1;
      src0_valid = v0; src0_data = d0;
      src1_valid = v1; src1_data = d1;
      @(negedge clk);
      free = DEPTH - mocc;
      er0  = (free >= 1);
      er1  = (free >= 2) || (free >= 1 && !v0);
      if (free == 1 && v0) saw_split++;
      checks++;
      if (src0_ready !== er0 || src1_ready !== er1 || occupancy !== CW'(mocc)
          || belt_push !== (mocc != 0)) begin
        errors++;
        $display("FAIL bp_cycle[%0d]: r0=%b r1=%b occ=%0d push=%b, required %b %b %0d %b",
                 c, src0_ready, src1_ready, occupancy, belt_push, er0, er1, mocc, (mocc != 0));
      end
      a0 = v0 & er0;
      a1 = v1 & er1;
      if (a0) exp_q.push_back(d0);
      if (a1) exp_q.push_back(d1);
      mocc = mocc + int'(a0) + int'(a1) - ((mocc != 0) ? 1 : 0);
      p0 = v0 & ~a0;
      p1 = v1 & ~a1;
      step();
    end
    checks++;
    if (saw_split == 0) begin
      errors++;
      $display("FAIL bp_coverage: free=1 with src0 valid seen %0d times, required > 0", saw_split);
    end
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    while (got_rd < got_wr) begin
      g = got_mem[got_rd];
      got_rd++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL bp_sb_extra: got %h, required no push", g);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL bp_sb: got %h required %h", g, e);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_sb_missing: %0d values never pushed, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] g, e, x;
    x = 47'h7F00_0000_0F1F;
    src0_valid = 1'b1; src0_data = 47'h301;
    src1_valid = 1'b1; src1_data = 47'h302;
    exp_q.push_back(47'h301);
    step();
    src0_data = 47'h303;
    src1_data = 47'h304;
    step();
    src1_valid = 1'b0;
    src0_data  = x;
    flush      = 1'b1;
    @(negedge clk);
    checks++;
    if (occupancy !== CW'(3) || src0_ready !== 1'b0 || src1_ready !== 1'b0 || belt_push !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle: occ=%0d r0=%b r1=%b push=%b, required 3 0 0 0",
               occupancy, src0_ready, src1_ready, belt_push);
    end
    step();
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (occupancy !== '0 || src0_ready !== 1'b1 || belt_push !== 1'b0) begin
      errors++;
      $display("FAIL flush_after: occ=%0d r0=%b push=%b, required 0 1 0", occupancy, src0_ready, belt_push);
    end
    exp_q.push_back(x);
    step();
    src0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (occupancy !== CW'(1) || belt_push !== 1'b1 || belt_data !== x) begin
      errors++;
      $display("FAIL flush_resume: occ=%0d push=%b data=%h, required 1 1 %h", occupancy, belt_push, belt_data, x);
    end
    step();
    step();
    while (got_rd < got_wr) begin
      g = got_mem[got_rd];
      got_rd++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL flush_sb_extra: got %h, required no push", g);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL flush_sb: got %h required %h", g, e);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL flush_sb_missing: %0d values never pushed, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_clk_en();
    logic [W-1:0] g, e, p, q;
    p = 47'h1234_5678_9ABC;
    q = 47'h0FED_CBA9_8765;
    src0_valid = 1'b1; src0_data = p;
    src1_valid = 1'b1; src1_data = q;
    exp_q.push_back(p);
    exp_q.push_back(q);
    step();
    clk_en     = 1'b0;
    src0_data  = 47'h555;
    src1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      @(negedge clk);
      checks++;
      if (belt_push !== 1'b0 || src0_ready !== 1'b0 || src1_ready !== 1'b0 || occupancy !== CW'(2)) begin
        errors++;
        $display("FAIL gate[%0d]: push=%b r0=%b r1=%b occ=%0d, required 0 0 0 2",
                 i, belt_push, src0_ready, src1_ready, occupancy);
      end
      step();
    end
    clk_en     = 1'b1;
    flush      = 1'b0;
    src0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (belt_push !== 1'b1 || belt_data !== p || occupancy !== CW'(2)) begin
      errors++;
      $display("FAIL gate_resume: push=%b data=%h occ=%0d, required 1 %h 2", belt_push, belt_data, occupancy, p);
    end
    step();
    step();
    step();
    while (got_rd < got_wr) begin
      g = got_mem[got_rd];
      got_rd++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL gate_sb_extra: got %h, required no push", g);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL gate_sb: got %h required %h", g, e);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL gate_sb_missing: %0d values never pushed, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    async_rst = 1'b1;
    idle_inputs();
    test_reset();
    test_dual_write();
    test_wrap();
    test_backpressure();
    test_flush();
    test_clk_en();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
